// File: rtl/exp_arbiter_if.sv
// Exception arbiter bus: CPU/CP0-side controls in, request/EPC/status out.
// The master modport is the CPU side; the slave modport is the arbiter.
interface exp_arbiter_if #(
  parameter int unsigned NSRC = 4
);
  logic [NSRC-1:0] irq;
  logic            mask_we;
  logic [NSRC-1:0] mask_wdata;
  logic            glb_block;
  logic [31:0]     pc_in;
  logic            eret;
  logic            exp_ack;
  logic            exp_req;
  logic [2:0]      exp_code;
  logic [31:0]     epc_out;
  logic [NSRC-1:0] pending;
  logic            in_service;
  logic            tmo_flag;

  modport master (
    output irq, mask_we, mask_wdata, glb_block, pc_in, eret, exp_ack,
    input  exp_req, exp_code, epc_out, pending, in_service, tmo_flag
  );

  modport slave (
    input  irq, mask_we, mask_wdata, glb_block, pc_in, eret, exp_ack,
    output exp_req, exp_code, epc_out, pending, in_service, tmo_flag
  );
endinterface

// File: rtl/exp_arbiter.sv
// Edge-triggered exception arbiter: pending/mask, fixed low-index priority, IDLE/REQ/SVC handshake.
// Optional request timeout enabled by defining EXP_TMO_EN.
module exp_arbiter #(
  parameter int unsigned NSRC    = 4,
  parameter int unsigned TMO_CYC = 16
) (
  input logic         clk,
  input logic         reset,
  exp_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  if (NSRC < 2 || NSRC > 8 || TMO_CYC < 1) begin : g_bad_param
    $error("exp_arbiter: NSRC must be 2..8 and TMO_CYC at least 1");
  end

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [NSRC-1:0] r_irq_prev;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_elig;
  logic [NSRC-1:0] w_clr;
  logic [2:0]      r_code;
  logic [2:0]      w_win;
  logic [31:0]     r_epc;
  logic            r_exp_req;
  logic            r_in_service;
  logic            r_tmo_flag;
  logic            w_ack;
  logic            w_grant;
  logic            w_tmo_hit;

  assign w_edge  = bus.irq & ~r_irq_prev;
  assign w_elig  = r_pending & ~r_mask;
  assign w_ack   = (r_state == S_REQ) && bus.exp_ack;
  assign w_grant = (r_state == S_IDLE) && (w_state_nxt == S_REQ);
  assign w_clr   = w_ack ? (NSRC'(1) << r_code) : '0;

  // Lowest eligible index wins.
  always_comb begin
    w_win = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = 3'(i);
    end
  end

`ifdef EXP_TMO_EN
  localparam int unsigned TW = $clog2(TMO_CYC) + 1;
  logic [TW-1:0] r_tmo_cnt;

  // Counts cycles spent in REQ; restarts on every entry.
  always_ff @(posedge clk) begin
    if (reset || r_state != S_REQ) r_tmo_cnt <= '0;
    else                           r_tmo_cnt <= r_tmo_cnt + TW'(1);
  end

  assign w_tmo_hit = (r_state == S_REQ) && (r_tmo_cnt == TW'(TMO_CYC - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Ack beats timeout in the same cycle; eret only matters in SVC.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_elig != '0 && !bus.glb_block) w_state_nxt = S_REQ;
      S_REQ: begin
        if (bus.exp_ack)    w_state_nxt = S_SVC;
        else if (w_tmo_hit) w_state_nxt = S_IDLE;
      end
      S_SVC:   if (bus.eret) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_prev   <= '0;
      r_pending    <= '0;
      r_mask       <= '0;
      r_code       <= '0;
      r_epc        <= '0;
      r_exp_req    <= 1'b0;
      r_in_service <= 1'b0;
      r_tmo_flag   <= 1'b0;
    end else begin
      r_irq_prev   <= bus.irq;
      r_pending    <= (r_pending & ~w_clr) | w_edge;
      r_exp_req    <= (w_state_nxt == S_REQ);
      r_in_service <= (w_state_nxt == S_SVC);
      if (bus.mask_we) r_mask <= bus.mask_wdata;
      if (w_grant) begin
        r_code <= w_win;
        r_epc  <= bus.pc_in;
      end
      if (w_tmo_hit && !bus.exp_ack) r_tmo_flag <= 1'b1;
    end
  end

  assign bus.exp_req    = r_exp_req;
  assign bus.exp_code   = r_code;
  assign bus.epc_out    = r_epc;
  assign bus.pending    = r_pending;
  assign bus.in_service = r_in_service;
  assign bus.tmo_flag   = r_tmo_flag;

endmodule

// File: tb/tb_exp_arbiter.sv
// Self-checking bench for exp_arbiter: directed vector table, hand sequences and a randomized run
// against a cycle-level behavioural model.
module tb_exp_arbiter;
  localparam int unsigned NSRC = 4;
  localparam int unsigned TMO  = 16;
`ifdef EXP_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  exp_arbiter_if #(.NSRC(NSRC)) bus ();

  exp_arbiter #(.NSRC(NSRC), .TMO_CYC(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  logic [NSRC-1:0] m_prev, m_pend, m_mask;
  logic [31:0]     m_epc;
  bit              m_req, m_svc, m_tmo;
  int              m_code, m_reqcyc;

  function automatic int lowest(logic [NSRC-1:0] v);
    for (int i = 0; i < int'(NSRC); i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    logic [NSRC-1:0] edges, elig, clr;
    if (reset) begin
      m_prev = '0; m_pend = '0; m_mask = '0; m_epc = '0;
      m_req = 0; m_svc = 0; m_tmo = 0; m_code = 0; m_reqcyc = 0;
      return;
    end
    edges = bus.irq & ~m_prev;
    elig  = m_pend & ~m_mask;
    clr   = '0;
    if (m_req) begin
      if (bus.exp_ack) begin
        m_req = 0; m_svc = 1; clr[m_code] = 1'b1;
      end else if (TMO_EN && m_reqcyc + 1 == int'(TMO)) begin
        m_req = 0; m_tmo = 1;
      end else begin
        m_reqcyc++;
      end
    end else if (m_svc) begin
      if (bus.eret) m_svc = 0;
    end else if (elig != '0 && !bus.glb_block) begin
      m_req = 1; m_reqcyc = 0; m_code = lowest(elig); m_epc = bus.pc_in;
    end
    m_pend = (m_pend & ~clr) | edges;
    m_prev = bus.irq;
    if (bus.mask_we) m_mask = bus.mask_wdata;
  endtask

  task automatic check_model(input string name);
    checks++;
    if (bus.exp_req !== m_req || bus.exp_code !== 3'(m_code) || bus.epc_out !== m_epc ||
        bus.pending !== m_pend || bus.in_service !== m_svc || bus.tmo_flag !== m_tmo) begin
      failures++;
      $display("FAIL %s t=%0t: got req=%0b code=%0d epc=%h pend=%b svc=%0b tmo=%0b, want req=%0b code=%0d epc=%h pend=%b svc=%0b tmo=%0b",
               name, $time, bus.exp_req, bus.exp_code, bus.epc_out, bus.pending, bus.in_service,
               bus.tmo_flag, m_req, m_code, m_epc, m_pend, m_svc, m_tmo);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // One clock: inputs already applied are sampled, then DUT and model are compared.
  task automatic cycle(input string name);
    @(posedge clk);
    #1;
    model_step();
    check_model(name);
  endtask

  task automatic idle_inputs();
    bus.irq = '0; bus.mask_we = 0; bus.mask_wdata = '0; bus.glb_block = 0;
    bus.pc_in = '0; bus.eret = 0; bus.exp_ack = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle("reset");
    cycle("reset");
    reset = 1'b0;
  endtask

  typedef struct {
    logic [NSRC-1:0] irq;
    logic            mwe;
    logic [NSRC-1:0] mwd;
    logic            gb;
    logic            er;
    logic            ak;
    logic            req;
    logic [2:0]      code;
    logic [NSRC-1:0] pend;
    logic            svc;
  } vec_t;

  function automatic vec_t mk(logic [3:0] irq, logic mwe, logic [3:0] mwd, logic gb, logic er,
                              logic ak, logic req, logic [2:0] code, logic [3:0] pend, logic svc);
    vec_t v;
    v.irq = irq; v.mwe = mwe; v.mwd = mwd; v.gb = gb; v.er = er; v.ak = ak;
    v.req = req; v.code = code; v.pend = pend; v.svc = svc;
    return v;
  endfunction

  vec_t tbl[28];

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    idle_inputs();

    //             irq     mwe mwd     gb er ak   req code pend    svc
    tbl[0]  = mk(4'b1010, 0, 4'b0000, 0, 0, 0,   0, 0, 4'b1010, 0);
    tbl[1]  = mk(4'b1010, 0, 4'b0000, 0, 0, 0,   1, 1, 4'b1010, 0);
    tbl[2]  = mk(4'b1010, 0, 4'b0000, 0, 0, 1,   0, 1, 4'b1000, 1);
    tbl[3]  = mk(4'b1010, 0, 4'b0000, 0, 0, 0,   0, 1, 4'b1000, 1);
    tbl[4]  = mk(4'b1010, 0, 4'b0000, 0, 1, 0,   0, 1, 4'b1000, 0);
    tbl[5]  = mk(4'b1010, 0, 4'b0000, 0, 0, 0,   1, 3, 4'b1000, 0);
    tbl[6]  = mk(4'b1010, 0, 4'b0000, 0, 0, 1,   0, 3, 4'b0000, 1);
    tbl[7]  = mk(4'b0000, 0, 4'b0000, 0, 1, 0,   0, 3, 4'b0000, 0);
    tbl[8]  = mk(4'b0000, 1, 4'b0001, 0, 0, 0,   0, 3, 4'b0000, 0);
    tbl[9]  = mk(4'b0001, 0, 4'b0000, 0, 0, 0,   0, 3, 4'b0001, 0);
    tbl[10] = mk(4'b0001, 0, 4'b0000, 0, 0, 0,   0, 3, 4'b0001, 0);
    tbl[11] = mk(4'b0001, 1, 4'b0000, 0, 0, 0,   0, 3, 4'b0001, 0);
    tbl[12] = mk(4'b0001, 0, 4'b0000, 0, 0, 0,   1, 0, 4'b0001, 0);
    tbl[13] = mk(4'b0000, 0, 4'b0000, 0, 0, 0,   1, 0, 4'b0001, 0);
    tbl[14] = mk(4'b0001, 0, 4'b0000, 0, 0, 1,   0, 0, 4'b0001, 1);
    tbl[15] = mk(4'b0001, 0, 4'b0000, 0, 1, 0,   0, 0, 4'b0001, 0);
    tbl[16] = mk(4'b0001, 0, 4'b0000, 0, 0, 0,   1, 0, 4'b0001, 0);
    tbl[17] = mk(4'b0001, 0, 4'b0000, 0, 0, 1,   0, 0, 4'b0000, 1);
    tbl[18] = mk(4'b0000, 0, 4'b0000, 1, 0, 0,   0, 0, 4'b0000, 1);
    tbl[19] = mk(4'b0000, 0, 4'b0000, 1, 1, 0,   0, 0, 4'b0000, 0);
    tbl[20] = mk(4'b0010, 0, 4'b0000, 1, 0, 0,   0, 0, 4'b0010, 0);
    tbl[21] = mk(4'b0010, 0, 4'b0000, 1, 0, 0,   0, 0, 4'b0010, 0);
    tbl[22] = mk(4'b0010, 0, 4'b0000, 1, 1, 0,   0, 0, 4'b0010, 0);
    tbl[23] = mk(4'b0010, 0, 4'b0000, 0, 0, 0,   1, 1, 4'b0010, 0);
    tbl[24] = mk(4'b0010, 0, 4'b0000, 1, 0, 0,   1, 1, 4'b0010, 0);
    tbl[25] = mk(4'b0010, 0, 4'b0000, 1, 1, 0,   1, 1, 4'b0010, 0);
    tbl[26] = mk(4'b0010, 0, 4'b0000, 1, 0, 1,   0, 1, 4'b0000, 1);
    tbl[27] = mk(4'b0010, 0, 4'b0000, 0, 0, 1,   0, 1, 4'b0000, 1);

    do_reset();
    check_val("reset_outputs",
              {bus.exp_req, 1'b0, bus.exp_code, bus.pending, bus.in_service, bus.tmo_flag},
              32'd0);
    check_val("reset_epc", bus.epc_out, 32'd0);

    // Two-cycle request latency with EPC capture, then frozen grant.
    cycle("idle");
    bus.irq = 4'b0100; bus.pc_in = 32'h0040_0020;
    cycle("lat_edge");
    check_val("lat_n1_req", 32'(bus.exp_req), 32'd0);
    check_val("lat_n1_pend", 32'(bus.pending), 32'h4);
    cycle("lat_grant");
    check_val("lat_n2_req", 32'(bus.exp_req), 32'd1);
    check_val("lat_n2_code", 32'(bus.exp_code), 32'd2);
    check_val("lat_n2_epc", bus.epc_out, 32'h0040_0020);
    bus.irq = 4'b0101; bus.pc_in = 32'h0000_1234;
    cycle("frozen");
    check_val("frozen_code", 32'(bus.exp_code), 32'd2);
    check_val("frozen_epc", bus.epc_out, 32'h0040_0020);

    idle_inputs();
    do_reset();
    for (int k = 0; k < 28; k++) begin
      bus.irq = tbl[k].irq; bus.mask_we = tbl[k].mwe; bus.mask_wdata = tbl[k].mwd;
      bus.glb_block = tbl[k].gb; bus.eret = tbl[k].er; bus.exp_ack = tbl[k].ak;
      bus.pc_in = 32'h1000 + 32'(k * 4);
      cycle("table_model");
      checks++;
      if (bus.exp_req !== tbl[k].req || bus.exp_code !== tbl[k].code ||
          bus.pending !== tbl[k].pend || bus.in_service !== tbl[k].svc) begin
        failures++;
        $display("FAIL table[%0d]: got req=%0b code=%0d pend=%b svc=%0b want req=%0b code=%0d pend=%b svc=%0b",
                 k, bus.exp_req, bus.exp_code, bus.pending, bus.in_service,
                 tbl[k].req, tbl[k].code, tbl[k].pend, tbl[k].svc);
      end
    end

    // Reset while servicing source 1 abandons everything.
    bus.exp_ack = 0; bus.eret = 0; bus.glb_block = 0;
    check_val("pre_reset_svc", {30'd0, bus.in_service, bus.exp_code == 3'd1}, 32'd3);
    reset = 1'b1;
    cycle("reset_in_svc");
    reset = 1'b0;
    check_val("rst_svc_outputs",
              {bus.exp_req, 1'b0, bus.exp_code, bus.pending, bus.in_service, bus.tmo_flag},
              32'd0);
    check_val("rst_svc_epc", bus.epc_out, 32'd0);
    bus.irq = '0;
    cycle("after_reset");
    check_val("rst_svc_idle", 32'(bus.exp_req), 32'd0);

`ifdef EXP_TMO_EN
    idle_inputs();
    do_reset();
    bus.irq = 4'b0001;
    cycle("tmo_edge");
    cycle("tmo_grant");
    check_val("tmo_granted", 32'(bus.exp_req), 32'd1);
    for (int k = 0; k < int'(TMO) - 1; k++) cycle("tmo_wait");
    check_val("tmo_still_req", 32'(bus.exp_req), 32'd1);
    cycle("tmo_expire");
    check_val("tmo_req_drop", 32'(bus.exp_req), 32'd0);
    check_val("tmo_flag", 32'(bus.tmo_flag), 32'd1);
    check_val("tmo_pending", 32'(bus.pending[0]), 32'd1);
`else
    check_val("tmo_tied_low", 32'(bus.tmo_flag), 32'd0);
`endif

    // Randomized run against the model.
    idle_inputs();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset          = ($urandom_range(0, 149) == 0);
      bus.irq        = NSRC'($urandom);
      bus.mask_we    = ($urandom_range(0, 7) == 0);
      bus.mask_wdata = NSRC'($urandom) & NSRC'($urandom);
      bus.glb_block  = ($urandom_range(0, 3) == 0);
      bus.eret       = ($urandom_range(0, 3) == 0);
      bus.exp_ack    = ($urandom_range(0, 2) == 0);
      bus.pc_in      = $urandom;
      cycle("random");
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
